// File: rtl/fifo_vc_pkg.sv
// fifo_vc_pkg: shared sizing helpers for the multi-VC FIFO and its per-VC queues.
package fifo_vc_pkg;
  localparam int DEPTH_DEF = 4;
  function automatic int vcw_f(input int vc_num);
    return (vc_num > 1) ? $clog2(vc_num) : 1;
  endfunction
  function automatic int ptrw_f(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cntw_f(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_vc_sync.sv
// fifo_sync: single-VC synchronous FWFT FIFO with registered full/empty and reject strobes.
module fifo_sync
  import fifo_vc_pkg::*;
#(
  parameter int width = 32,
  parameter int depth = DEPTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [width-1:0] data_i,
  output logic [width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             push_rej_o,
  output logic             pop_rej_o
);
  localparam int PW = ptrw_f(depth);
  localparam int CW = cntw_f(depth);
  logic [width-1:0] mem_q [depth];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic full_q, empty_q, push_ok, pop_ok;
  // A full queue still takes a write when the same edge frees its head slot.
  always_comb begin
    pop_ok = pop_i && (cnt_q != '0);
    push_ok = push_i && ((cnt_q != CW'(depth)) || pop_ok);
    cnt_d = (push_ok && !pop_ok) ? cnt_q + 1'b1 :
            (pop_ok && !push_ok) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_q + PW'(push_ok);
      rd_ptr_q <= rd_ptr_q + PW'(pop_ok);
      cnt_q <= cnt_d;
      full_q <= cnt_d == CW'(depth);
      empty_q <= cnt_d == '0;
    end
  end
  assign data_o = mem_q[rd_ptr_q];
  assign full_o = full_q;
  assign empty_o = empty_q;
  assign push_rej_o = push_i && !push_ok;
  assign pop_rej_o = pop_i && !pop_ok;
endmodule

// File: rtl/fifo_vc.sv
// fifo_vc: vc_num independent FWFT queues sharing one write and one read port,
// with registered per-VC full/empty and sticky overflow/underflow flags.
module fifo_vc
  import fifo_vc_pkg::*;
#(
  parameter int width = 32,
  parameter int depth = DEPTH_DEF,
  parameter int vc_num = 2,
  localparam int vcw = vcw_f(vc_num)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              write_i,
  input  logic [vcw-1:0]    wr_vc_i,
  input  logic [width-1:0]  data_i,
  input  logic              read_i,
  input  logic [vcw-1:0]    rd_vc_i,
  output logic [width-1:0]  data_o,
  output logic [vc_num-1:0] empty_o,
  output logic [vc_num-1:0] full_o,
  output logic              ovf_o,
  output logic              udf_o
);
  logic wr_in, rd_in, ovf_q, ovf_d, udf_q, udf_d;
  logic [vc_num-1:0] push, pop, push_rej, pop_rej;
  logic [width-1:0] head [vc_num];
  assign wr_in = 32'(wr_vc_i) < vc_num;
  assign rd_in = 32'(rd_vc_i) < vc_num;
  for (genvar v = 0; v < vc_num; v++) begin : g_vc
    assign push[v] = write_i && wr_in && (wr_vc_i == vcw'(v));
    assign pop[v] = read_i && rd_in && (rd_vc_i == vcw'(v));
    fifo_sync #(.width(width), .depth(depth)) u_q (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (push[v]),
      .pop_i     (pop[v]),
      .data_i    (data_i),
      .data_o    (head[v]),
      .full_o    (full_o[v]),
      .empty_o   (empty_o[v]),
      .push_rej_o(push_rej[v]),
      .pop_rej_o (pop_rej[v])
    );
  end
  assign data_o = rd_in ? head[rd_vc_i] : '0;
  // Out-of-range VC selects never reach a queue, so they are flagged here.
  always_comb begin
    ovf_d = ovf_q || (write_i && !wr_in) || (|push_rej);
    udf_d = udf_q || (read_i && !rd_in) || (|pop_rej);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
endmodule

// File: tb/tb_fifo_vc.sv
// tb_fifo_vc: directed and randomized checks of fifo_vc against a queue-based model.
module tb_fifo_vc;
  logic        clk_i = 1'b0, rst_i = 1'b0, write_i = 1'b0, read_i = 1'b0;
  logic [0:0]  wr_vc_i = '0, rd_vc_i = '0;
  logic [31:0] data_i = '0, data_o;
  logic [1:0]  empty_o, full_o;
  logic        ovf_o, udf_o;
  int          pass_n = 0, total_n = 0;
  logic [31:0] q0[$], q1[$];
  bit          m_ovf, m_udf;

  fifo_vc #(.width(32), .depth(4), .vc_num(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .write_i(write_i), .wr_vc_i(wr_vc_i),
    .data_i(data_i), .read_i(read_i), .rd_vc_i(rd_vc_i), .data_o(data_o),
    .empty_o(empty_o), .full_o(full_o), .ovf_o(ovf_o), .udf_o(udf_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int qsize(input bit v);
    return v ? q1.size() : q0.size();
  endfunction
  function automatic logic [31:0] front(input bit v);
    return v ? q1[0] : q0[0];
  endfunction
  function automatic logic [5:0] exp_flags();
    return {q1.size() == 4, q0.size() == 4, q1.size() == 0, q0.size() == 0, m_ovf, m_udf};
  endfunction

  task automatic apply_reset();
    rst_i = 1'b0; write_i = 1'b1; wr_vc_i = 1'b0; data_i = 32'hDEAD; read_i = 1'b1; rd_vc_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b1; write_i = 1'b0; read_i = 1'b0;
    q0.delete(); q1.delete(); m_ovf = 0; m_udf = 0;
  endtask

  task automatic step(input bit w, input bit wv, input logic [31:0] d, input bit r, input bit rv);
    bit pop_ok, push_ok;
    write_i = w; wr_vc_i = wv; data_i = d; read_i = r; rd_vc_i = rv;
    pop_ok = r && qsize(rv) > 0;
    push_ok = w && (qsize(wv) < 4 || (pop_ok && rv == wv));
    @(posedge clk_i); #1;
    write_i = 1'b0; read_i = 1'b0;
    if (w && !push_ok) m_ovf = 1;
    if (r && !pop_ok) m_udf = 1;
    if (pop_ok) begin
      if (rv) void'(q1.pop_front()); else void'(q0.pop_front());
    end
    if (push_ok) begin
      if (wv) q1.push_back(d); else q0.push_back(d);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(posedge clk_i); #1;
    total_n++;
    if ({full_o, empty_o, ovf_o, udf_o} !== 6'b00_11_00)
      $display("FAIL reset_flags: got %b expected %b", {full_o, empty_o, ovf_o, udf_o}, 6'b00_11_00);
    else pass_n++;
    for (int v = 0; v < 2; v++) begin
      rd_vc_i = 1'(v); #1;
      total_n++;
      if (data_o !== 32'h0) $display("FAIL reset_data vc%0d: got %h expected 0", v, data_o);
      else pass_n++;
    end
  endtask

  task automatic test_fill_drain();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 32'hA0 + 32'(i), 0, 0);
      total_n++;
      if (full_o[1] !== (i == 3)) $display("FAIL fill_full%0d: got %b expected %b", i, full_o[1], i == 3);
      else pass_n++;
    end
    for (int i = 0; i < 4; i++) begin
      rd_vc_i = 1'b1; #1;
      total_n++;
      if (data_o !== 32'hA0 + 32'(i)) $display("FAIL drain_data%0d: got %h expected %h", i, data_o, 32'hA0 + 32'(i));
      else pass_n++;
      step(0, 0, 0, 1, 1);
    end
    total_n++;
    if ({full_o, empty_o, ovf_o, udf_o} !== 6'b00_11_00)
      $display("FAIL drain_flags: got %b expected %b", {full_o, empty_o, ovf_o, udf_o}, 6'b00_11_00);
    else pass_n++;
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 32'hA0 + 32'(i), 0, 0);
    step(1, 1, 32'hBB, 0, 1);
    total_n++;
    if ({full_o[1], ovf_o, data_o} !== {1'b1, 1'b1, 32'hA0})
      $display("FAIL ovf_drop: got full=%b ovf=%b data=%h expected full=1 ovf=1 data=a0", full_o[1], ovf_o, data_o);
    else pass_n++;
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 32'hA0 + 32'(i), 0, 0);
    step(1, 1, 32'hCC, 1, 1);
    total_n++;
    if ({full_o[1], ovf_o, udf_o, data_o} !== {1'b1, 1'b0, 1'b0, 32'hA1})
      $display("FAIL ovf_pass: got full=%b ovf=%b udf=%b data=%h expected full=1 ovf=0 udf=0 data=a1", full_o[1], ovf_o, udf_o, data_o);
    else pass_n++;
    for (int i = 0; i < 4; i++) begin
      rd_vc_i = 1'b1; #1;
      total_n++;
      if (data_o !== front(1)) $display("FAIL ovf_order%0d: got %h expected %h", i, data_o, front(1));
      else pass_n++;
      step(0, 0, 0, 1, 1);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    step(1, 0, 32'h55, 1, 0);
    total_n++;
    if ({udf_o, ovf_o, empty_o[0], data_o} !== {1'b1, 1'b0, 1'b0, 32'h55})
      $display("FAIL udf_write: got udf=%b ovf=%b empty0=%b data=%h expected udf=1 ovf=0 empty0=0 data=55", udf_o, ovf_o, empty_o[0], data_o);
    else pass_n++;
  endtask

  task automatic test_interleaved();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 0, $urandom, 0, 0);
      step(1, 1, $urandom, 0, 0);
    end
    for (int i = 0; i < 14; i++) begin
      step(1, 1'(i), 32'h1100 + 32'(i), 1, 1'(i + 1));
      total_n++;
      if ({full_o, empty_o, ovf_o, udf_o} !== exp_flags())
        $display("FAIL ilv_flags%0d: got %b expected %b", i, {full_o, empty_o, ovf_o, udf_o}, exp_flags());
      else pass_n++;
      for (int v = 0; v < 2; v++) begin
        rd_vc_i = 1'(v); #1;
        if (qsize(1'(v)) > 0) begin
          total_n++;
          if (data_o !== front(1'(v))) $display("FAIL ilv_head%0d vc%0d: got %h expected %h", i, v, data_o, front(1'(v)));
          else pass_n++;
        end
      end
    end
  endtask

  task automatic test_random();
    bit w, wv, r, rv;
    logic [31:0] d;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) apply_reset();
      w = $urandom_range(0, 99) < 60; wv = 1'($urandom); r = $urandom_range(0, 99) < 50;
      rv = 1'($urandom); d = $urandom;
      step(w, wv, d, r, rv);
      total_n++;
      if ({full_o, empty_o, ovf_o, udf_o} !== exp_flags())
        $display("FAIL rnd_flags%0d: got %b expected %b", i, {full_o, empty_o, ovf_o, udf_o}, exp_flags());
      else pass_n++;
      for (int v = 0; v < 2; v++) begin
        rd_vc_i = 1'(v); #1;
        if (qsize(1'(v)) > 0) begin
          total_n++;
          if (data_o !== front(1'(v))) $display("FAIL rnd_head%0d vc%0d: got %h expected %h", i, v, data_o, front(1'(v)));
          else pass_n++;
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    step(1, 0, 32'h77, 0, 0);
    step(1, 1, 32'h88, 0, 0);
    step(1, 1, 32'h99, 1, 0);
    apply_reset();
    total_n++;
    if ({full_o, empty_o, ovf_o, udf_o} !== 6'b00_11_00)
      $display("FAIL mrst_flags: got %b expected %b", {full_o, empty_o, ovf_o, udf_o}, 6'b00_11_00);
    else pass_n++;
    for (int v = 0; v < 2; v++) begin
      rd_vc_i = 1'(v); #1;
      total_n++;
      if (data_o !== 32'h0) $display("FAIL mrst_data vc%0d: got %h expected 0", v, data_o);
      else pass_n++;
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_interleaved();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
